ascon_serial_host: RTL and testbench

Host-side driver for the bit-serial Ascon core interface. Takes one parallel request (key, nonce, associated data, data block, direction), shifts it onto the core's serial input lanes and pulses start. It then waits for ready and deserialises the output-data and tag lanes back into parallel words. It sits between the SoC/test logic and the Ascon core, as the counterpart of the core's serial pin interface.

---
 rtl/ascon_serial_host_pkg.sv | 25 ++
 rtl/ascon_serial_host_shift_lane.sv | 28 ++
 rtl/ascon_serial_host.sv | 193 +++++++++++++++++++
 tb/tb_ascon_serial_host.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_serial_host_pkg.sv
// Shared types and default geometry for the Ascon serial host driver.
package ascon_serial_host_pkg;

    localparam int DEF_KEY_W   = 128;
    localparam int DEF_AD_W    = 64;
    localparam int DEF_DATA_W  = 64;
    localparam int DEF_TAG_W   = 128;
    localparam int DEF_TIMEOUT = 1023;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        CAPTURE,
        RESP
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ascon_serial_host_shift_lane.sv
// Width-N shift register: parallel load, MSB-first shift-out, LSB shift-in.
module ascon_shift_lane #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         shift_en,
    input  logic         shift_in,
    output logic [N-1:0] q,
    output logic         msb
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift_en) begin
            // Truncating the concatenation drops the old MSB, which also works for N == 1.
            q <= N'({q, shift_in});
        end
    end

    assign msb = q[N-1];

endmodule

// File: rtl/ascon_serial_host.sv
// Host driver: serialises one request onto the Ascon core lanes, then deserialises
// the returned data and tag (or reports a timeout if the core never becomes ready).
module ascon_serial_host
    import ascon_serial_host_pkg::*;
#(
    parameter int KEY_W   = DEF_KEY_W,
    parameter int AD_W    = DEF_AD_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_decrypt,
    input  logic [KEY_W-1:0]  req_key,
    input  logic [KEY_W-1:0]  req_nonce,
    input  logic [AD_W-1:0]   req_ad,
    input  logic [DATA_W-1:0] req_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [TAG_W-1:0]  resp_tag,
    output logic              resp_timeout,
    output logic              ser_key,
    output logic              ser_nonce,
    output logic              ser_ad,
    output logic              ser_data,
    output logic              ser_start,
    output logic              ser_decrypt,
    input  logic              ser_output_data,
    input  logic              ser_tag,
    input  logic              ser_ready
);

    localparam int CAP_W = (DATA_W > TAG_W) ? DATA_W : TAG_W;
    localparam int CNT_W = $clog2(max3(KEY_W, TAG_W, TIMEOUT + 1));

    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(KEY_W - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CAP_LAST  = CNT_W'(CAP_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] TAG_LAST  = CNT_W'(TAG_W - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;

    logic req_take, lane_shift, resp_clr, dat_cap, tag_cap;
    logic cnt_clr, cnt_inc, set_to, clr_dec;

    logic              key_msb, nonce_msb, ad_msb, data_msb;
    logic [KEY_W-1:0]  key_q_unused, nonce_q_unused;
    logic [AD_W-1:0]   ad_q_unused;
    logic [DATA_W-1:0] data_q_unused;
    logic              dat_msb_unused, tag_msb_unused;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_take   = 1'b0;
        lane_shift = 1'b0;
        resp_clr   = 1'b0;
        dat_cap    = 1'b0;
        tag_cap    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        set_to     = 1'b0;
        clr_dec    = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    req_take  = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                lane_shift = 1'b1;
                if (cnt == LOAD_LAST) begin
                    cnt_clr   = 1'b1;
                    state_nxt = START;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            START: begin
                cnt_clr   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                // Ready is tested before the timeout so a coincident ready still captures.
                if (ser_ready) begin
                    dat_cap   = 1'b1;
                    tag_cap   = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = CAPTURE;
                end else if (cnt == WAIT_LAST) begin
                    set_to    = 1'b1;
                    resp_clr  = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            CAPTURE: begin
                // Bit index 0 was taken on the ready cycle, so this cycle carries index cnt+1.
                dat_cap = (cnt < DATA_LAST);
                tag_cap = (cnt < TAG_LAST);
                if (cnt == CAP_LAST) begin
                    state_nxt = RESP;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    clr_dec   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            ser_decrypt  <= 1'b0;
            resp_timeout <= 1'b0;
        end else begin
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
            if (req_take) begin
                ser_decrypt  <= req_decrypt;
                resp_timeout <= 1'b0;
            end else begin
                if (clr_dec) ser_decrypt <= 1'b0;
                if (set_to) resp_timeout <= 1'b1;
            end
        end
    end

    // Serialisers shift in zeros, so short lanes fall silent once their width is exhausted.
    ascon_shift_lane #(.N(KEY_W)) u_key_lane (
        .clk(clk), .rst(rst), .load(req_take), .load_val(req_key),
        .shift_en(lane_shift), .shift_in(1'b0), .q(key_q_unused), .msb(key_msb)
    );

    ascon_shift_lane #(.N(KEY_W)) u_nonce_lane (
        .clk(clk), .rst(rst), .load(req_take), .load_val(req_nonce),
        .shift_en(lane_shift), .shift_in(1'b0), .q(nonce_q_unused), .msb(nonce_msb)
    );

    ascon_shift_lane #(.N(AD_W)) u_ad_lane (
        .clk(clk), .rst(rst), .load(req_take), .load_val(req_ad),
        .shift_en(lane_shift), .shift_in(1'b0), .q(ad_q_unused), .msb(ad_msb)
    );

    ascon_shift_lane #(.N(DATA_W)) u_data_lane (
        .clk(clk), .rst(rst), .load(req_take), .load_val(req_data),
        .shift_en(lane_shift), .shift_in(1'b0), .q(data_q_unused), .msb(data_msb)
    );

    ascon_shift_lane #(.N(DATA_W)) u_out_lane (
        .clk(clk), .rst(rst), .load(resp_clr), .load_val({DATA_W{1'b0}}),
        .shift_en(dat_cap), .shift_in(ser_output_data), .q(resp_data), .msb(dat_msb_unused)
    );

    ascon_shift_lane #(.N(TAG_W)) u_tag_lane (
        .clk(clk), .rst(rst), .load(resp_clr), .load_val({TAG_W{1'b0}}),
        .shift_en(tag_cap), .shift_in(ser_tag), .q(resp_tag), .msb(tag_msb_unused)
    );

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign ser_start  = (state == START);
    assign ser_key    = (state == LOAD) & key_msb;
    assign ser_nonce  = (state == LOAD) & nonce_msb;
    assign ser_ad     = (state == LOAD) & ad_msb;
    assign ser_data   = (state == LOAD) & data_msb;

endmodule

// File: tb/tb_ascon_serial_host.sv
// Bench for ascon_serial_host: a behavioural core model answers each request and
// lane sequences, latencies and responses are compared with values built from the request.
module tb_ascon_serial_host;

    localparam int KEY_W   = 128;
    localparam int AD_W    = 64;
    localparam int DATA_W  = 64;
    localparam int TAG_W   = 128;
    localparam int TIMEOUT = 1023;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_decrypt;
    logic [KEY_W-1:0]  req_key, req_nonce;
    logic [AD_W-1:0]   req_ad;
    logic [DATA_W-1:0] req_data;
    logic              resp_valid, resp_ready, resp_timeout;
    logic [DATA_W-1:0] resp_data;
    logic [TAG_W-1:0]  resp_tag;
    logic              ser_key, ser_nonce, ser_ad, ser_data, ser_start, ser_decrypt;
    logic              ser_output_data, ser_tag, ser_ready;

    int n_vec = 0;
    int n_err = 0;

    logic              acc_rdy, obs_hung, obs_rto;
    logic [KEY_W-1:0]  obs_key, obs_nonce, obs_ad, obs_data;
    logic [DATA_W-1:0] obs_rdata;
    logic [TAG_W-1:0]  obs_rtag;
    logic              obs_idle_valid, obs_idle_rdy, obs_idle_dec;
    int                obs_starts, obs_start_lanes, obs_dec_bad, obs_busy_rdy, obs_lat, obs_unstable;

    ascon_serial_host dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_decrypt(req_decrypt),
        .req_key(req_key), .req_nonce(req_nonce), .req_ad(req_ad), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_tag(resp_tag), .resp_timeout(resp_timeout),
        .ser_key(ser_key), .ser_nonce(ser_nonce), .ser_ad(ser_ad), .ser_data(ser_data),
        .ser_start(ser_start), .ser_decrypt(ser_decrypt),
        .ser_output_data(ser_output_data), .ser_tag(ser_tag), .ser_ready(ser_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got time %0t want < 2000000", $time);
        $fatal(1);
    end

    function automatic logic [127:0] r128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [63:0] r64();
        return {$urandom(), $urandom()};
    endfunction

    // One request plus core model. w = WAIT cycle (1-based) on which the core raises
    // ready, 0 = never. Observations land in obs_*; callers decide what to compare.
    task automatic run_txn(input logic dec, input logic [KEY_W-1:0] key, input logic [KEY_W-1:0] nonce,
                           input logic [AD_W-1:0] ad, input logic [DATA_W-1:0] data,
                           input logic [DATA_W-1:0] odata, input logic [TAG_W-1:0] tag,
                           input int w, input int hold, input logic second);
        int cyc, idx;
        obs_starts = 0; obs_dec_bad = 0; obs_busy_rdy = 0; obs_unstable = 0;
        acc_rdy = req_ready;
        req_decrypt = dec; req_key = key; req_nonce = nonce; req_ad = ad; req_data = data;
        req_valid = 1'b1; resp_ready = 1'b0; ser_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        for (int i = 0; i < KEY_W; i++) begin
            obs_key[KEY_W-1-i]   = ser_key;
            obs_nonce[KEY_W-1-i] = ser_nonce;
            obs_ad[KEY_W-1-i]    = ser_ad;
            obs_data[KEY_W-1-i]  = ser_data;
            if (ser_start) obs_starts++;
            if (ser_decrypt !== dec) obs_dec_bad++;
            if (req_ready) obs_busy_rdy++;
            @(negedge clk);
            cyc++;
        end
        obs_start_lanes = int'({ser_key, ser_nonce, ser_ad, ser_data});
        for (int k = 0; k < 1400; k++) begin
            if (resp_valid === 1'b1) break;
            if (ser_start) obs_starts++;
            if (ser_decrypt !== dec) obs_dec_bad++;
            if (req_ready) obs_busy_rdy++;
            idx = k - w;
            if (w > 0 && k == w) ser_ready = 1'b1;
            else if (w > 0 && k > w) ser_ready = 1'($urandom);
            else ser_ready = 1'b0;
            ser_output_data = (w > 0 && idx >= 0 && idx < DATA_W) ? odata[DATA_W-1-idx] : 1'($urandom);
            ser_tag         = (w > 0 && idx >= 0 && idx < TAG_W)  ? tag[TAG_W-1-idx]    : 1'($urandom);
            @(negedge clk);
            cyc++;
        end
        ser_ready = 1'b0;
        obs_hung = (resp_valid !== 1'b1);
        obs_lat = cyc;
        obs_rdata = resp_data; obs_rtag = resp_tag; obs_rto = resp_timeout;
        for (int h = 0; h < hold; h++) begin
            if (second) begin
                req_valid = 1'b1; req_key = r128(); req_nonce = r128(); req_decrypt = ~dec;
            end
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_data !== obs_rdata || resp_tag !== obs_rtag ||
                resp_timeout !== obs_rto) obs_unstable++;
            if (req_ready) obs_busy_rdy++;
            if (ser_decrypt !== dec) obs_dec_bad++;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0; req_valid = 1'b0;
        obs_idle_valid = resp_valid; obs_idle_rdy = req_ready; obs_idle_dec = ser_decrypt;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_decrypt = 1'b0; req_key = '0; req_nonce = '0;
        req_ad = '0; req_data = '0; resp_ready = 1'b0;
        ser_output_data = 1'b0; ser_tag = 1'b0; ser_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({req_ready, resp_valid, resp_timeout, ser_key, ser_nonce, ser_ad, ser_data, ser_start, ser_decrypt} !== 9'b100000000) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b want 100000000",
                     {req_ready, resp_valid, resp_timeout, ser_key, ser_nonce, ser_ad, ser_data, ser_start, ser_decrypt});
        end
        n_vec++;
        if (resp_data !== '0 || resp_tag !== '0) begin
            n_err++;
            $display("FAIL reset_resp: got %h/%h want 0/0", resp_data, resp_tag);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_encrypt_vector();
        logic [KEY_W-1:0]  key, nonce;
        logic [AD_W-1:0]   ad;
        logic [DATA_W-1:0] data, odata;
        logic [TAG_W-1:0]  tag;
        key = 128'h000102030405060708090A0B0C0D0E0F;
        nonce = 128'h101112131415161718191A1B1C1D1E1F;
        ad = 64'hA5A5A5A5A5A5A5A5; data = 64'h0123456789ABCDEF;
        odata = 64'hDEADBEEFCAFEF00D; tag = 128'h0F0E0D0C0B0A09080706050403020100;
        run_txn(1'b0, key, nonce, ad, data, odata, tag, 20, 0, 1'b0);
        n_vec++;
        if (acc_rdy !== 1'b1) begin n_err++; $display("FAIL enc_accept: got %b want 1", acc_rdy); end
        n_vec++;
        if (obs_key !== key) begin n_err++; $display("FAIL enc_key_lane: got %h want %h", obs_key, key); end
        n_vec++;
        if (obs_nonce !== nonce) begin n_err++; $display("FAIL enc_nonce_lane: got %h want %h", obs_nonce, nonce); end
        n_vec++;
        if (obs_ad !== {ad, {(KEY_W-AD_W){1'b0}}}) begin
            n_err++; $display("FAIL enc_ad_lane: got %h want %h", obs_ad, {ad, {(KEY_W-AD_W){1'b0}}});
        end
        n_vec++;
        if (obs_data !== {data, {(KEY_W-DATA_W){1'b0}}}) begin
            n_err++; $display("FAIL enc_data_lane: got %h want %h", obs_data, {data, {(KEY_W-DATA_W){1'b0}}});
        end
        n_vec++;
        if (obs_starts != 1) begin n_err++; $display("FAIL enc_start_pulses: got %0d want 1", obs_starts); end
        n_vec++;
        if (obs_start_lanes != 0) begin n_err++; $display("FAIL enc_start_lanes: got %0h want 0", obs_start_lanes); end
        n_vec++;
        if (obs_dec_bad != 0) begin n_err++; $display("FAIL enc_decrypt_lane: got %0d bad cycles want 0", obs_dec_bad); end
        n_vec++;
        if (obs_busy_rdy != 0) begin n_err++; $display("FAIL enc_busy_ready: got %0d cycles want 0", obs_busy_rdy); end
        n_vec++;
        if (obs_hung || obs_lat != 258 + 20) begin
            n_err++; $display("FAIL enc_latency: got %0d (hung %b) want %0d", obs_lat, obs_hung, 258 + 20);
        end
        n_vec++;
        if (obs_rdata !== odata) begin n_err++; $display("FAIL enc_resp_data: got %h want %h", obs_rdata, odata); end
        n_vec++;
        if (obs_rtag !== tag) begin n_err++; $display("FAIL enc_resp_tag: got %h want %h", obs_rtag, tag); end
        n_vec++;
        if (obs_rto !== 1'b0) begin n_err++; $display("FAIL enc_resp_timeout: got %b want 0", obs_rto); end
    endtask

    task automatic test_timeout();
        run_txn(1'b0, r128(), r128(), r64(), r64(), r64(), r128(), 0, 2, 1'b0);
        n_vec++;
        if (obs_hung || obs_lat != 128 + 1 + TIMEOUT + 1) begin
            n_err++; $display("FAIL timeout_latency: got %0d (hung %b) want %0d", obs_lat, obs_hung, 128 + 1 + TIMEOUT + 1);
        end
        n_vec++;
        if (obs_rto !== 1'b1 || obs_rdata !== '0 || obs_rtag !== '0) begin
            n_err++; $display("FAIL timeout_resp: got to=%b data=%h tag=%h want to=1 data=0 tag=0", obs_rto, obs_rdata, obs_rtag);
        end
        n_vec++;
        if (obs_unstable != 0) begin n_err++; $display("FAIL timeout_hold: got %0d unstable cycles want 0", obs_unstable); end
    endtask

    task automatic test_timeout_edge();
        logic [DATA_W-1:0] odata;
        logic [TAG_W-1:0]  tag;
        odata = r64(); tag = r128();
        run_txn(1'b0, r128(), r128(), r64(), r64(), odata, tag, TIMEOUT, 0, 1'b0);
        n_vec++;
        if (obs_hung || obs_lat != 258 + TIMEOUT) begin
            n_err++; $display("FAIL edge_latency: got %0d (hung %b) want %0d", obs_lat, obs_hung, 258 + TIMEOUT);
        end
        n_vec++;
        if (obs_rto !== 1'b0 || obs_rdata !== odata || obs_rtag !== tag) begin
            n_err++; $display("FAIL edge_resp: got to=%b data=%h tag=%h want to=0 data=%h tag=%h",
                              obs_rto, obs_rdata, obs_rtag, odata, tag);
        end
    endtask

    task automatic test_resp_hold();
        logic [DATA_W-1:0] odata;
        logic [TAG_W-1:0]  tag;
        odata = r64(); tag = r128();
        run_txn(1'b0, r128(), r128(), r64(), r64(), odata, tag, 7, 50, 1'b1);
        n_vec++;
        if (obs_unstable != 0) begin n_err++; $display("FAIL hold_stable: got %0d unstable cycles want 0", obs_unstable); end
        n_vec++;
        if (obs_busy_rdy != 0) begin n_err++; $display("FAIL hold_req_ready: got %0d cycles want 0", obs_busy_rdy); end
        n_vec++;
        if (obs_rdata !== odata || obs_rtag !== tag) begin
            n_err++; $display("FAIL hold_resp: got %h/%h want %h/%h", obs_rdata, obs_rtag, odata, tag);
        end
        n_vec++;
        if (obs_idle_valid !== 1'b0 || obs_idle_rdy !== 1'b1) begin
            n_err++; $display("FAIL hold_release: got valid=%b ready=%b want 0/1", obs_idle_valid, obs_idle_rdy);
        end
        odata = r64(); tag = r128();
        run_txn(1'b0, r128(), r128(), r64(), r64(), odata, tag, 3, 0, 1'b0);
        n_vec++;
        if (acc_rdy !== 1'b1 || obs_hung || obs_lat != 258 + 3) begin
            n_err++; $display("FAIL next_accept: got ready=%b lat=%0d want ready=1 lat=%0d", acc_rdy, obs_lat, 258 + 3);
        end
        n_vec++;
        if (obs_rdata !== odata || obs_rtag !== tag) begin
            n_err++; $display("FAIL next_resp: got %h/%h want %h/%h", obs_rdata, obs_rtag, odata, tag);
        end
    endtask

    task automatic test_decrypt();
        run_txn(1'b1, r128(), r128(), r64(), r64(), r64(), r128(), 12, 5, 1'b0);
        n_vec++;
        if (obs_dec_bad != 0) begin n_err++; $display("FAIL dec_held: got %0d bad cycles want 0", obs_dec_bad); end
        n_vec++;
        if (obs_idle_dec !== 1'b0) begin n_err++; $display("FAIL dec_idle: got %b want 0", obs_idle_dec); end
    endtask

    task automatic test_abort(input int abort_cyc, input string where);
        int n_valid, n_busy, w;
        logic [DATA_W-1:0] odata;
        logic [TAG_W-1:0]  tag;
        req_decrypt = 1'b1; req_key = r128(); req_nonce = r128(); req_ad = r64(); req_data = r64();
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c < abort_cyc; c++) begin
            ser_ready = (c == 134);
            ser_output_data = 1'($urandom); ser_tag = 1'($urandom);
            @(negedge clk);
        end
        n_vec++;
        if (ser_decrypt !== 1'b1 || req_ready !== 1'b0) begin
            n_err++; $display("FAIL abort_%s_busy: got dec=%b ready=%b want 1/0", where, ser_decrypt, req_ready);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({req_ready, resp_valid, resp_timeout, ser_key, ser_nonce, ser_ad, ser_data, ser_start, ser_decrypt} !== 9'b100000000) begin
            n_err++;
            $display("FAIL abort_%s_ctrl: got %b want 100000000", where,
                     {req_ready, resp_valid, resp_timeout, ser_key, ser_nonce, ser_ad, ser_data, ser_start, ser_decrypt});
        end
        n_vec++;
        if (resp_data !== '0 || resp_tag !== '0) begin
            n_err++; $display("FAIL abort_%s_resp: got %h/%h want 0/0", where, resp_data, resp_tag);
        end
        @(negedge clk);
        rst = 1'b0; ser_ready = 1'b1;
        n_valid = 0; n_busy = 0;
        repeat (400) begin
            @(negedge clk);
            if (resp_valid) n_valid++;
            if (!req_ready) n_busy++;
        end
        ser_ready = 1'b0;
        n_vec++;
        if (n_valid != 0 || n_busy != 0) begin
            n_err++; $display("FAIL abort_%s_quiet: got valid=%0d busy=%0d cycles want 0/0", where, n_valid, n_busy);
        end
        odata = r64(); tag = r128(); w = $urandom_range(1, 30);
        run_txn(1'b0, r128(), r128(), r64(), r64(), odata, tag, w, 0, 1'b0);
        n_vec++;
        if (obs_hung || obs_lat != 258 + w || obs_rdata !== odata || obs_rtag !== tag) begin
            n_err++; $display("FAIL abort_%s_fresh: got lat=%0d %h/%h want lat=%0d %h/%h",
                              where, obs_lat, obs_rdata, obs_rtag, 258 + w, odata, tag);
        end
    endtask

    task automatic test_back_to_back();
        logic [KEY_W-1:0]  key, nonce;
        logic [AD_W-1:0]   ad;
        logic [DATA_W-1:0] data, odata;
        logic [TAG_W-1:0]  tag;
        logic              dec;
        int                w;
        for (int t = 0; t < 4; t++) begin
            key = r128(); nonce = r128(); ad = r64(); data = r64(); odata = r64(); tag = r128();
            dec = 1'($urandom); w = $urandom_range(1, 40);
            run_txn(dec, key, nonce, ad, data, odata, tag, w, $urandom_range(0, 3), 1'b0);
            n_vec++;
            if (acc_rdy !== 1'b1 || obs_key !== key || obs_nonce !== nonce ||
                obs_ad !== {ad, {(KEY_W-AD_W){1'b0}}} || obs_data !== {data, {(KEY_W-DATA_W){1'b0}}}) begin
                n_err++; $display("FAIL b2b_%0d_lanes: got %h %h %h %h want %h %h %h %h", t,
                                  obs_key, obs_nonce, obs_ad, obs_data, key, nonce, {ad, 64'h0}, {data, 64'h0});
            end
            n_vec++;
            if (obs_starts != 1 || obs_dec_bad != 0 || obs_idle_dec !== 1'b0) begin
                n_err++; $display("FAIL b2b_%0d_ctrl: got starts=%0d dec_bad=%0d idle_dec=%b want 1/0/0",
                                  t, obs_starts, obs_dec_bad, obs_idle_dec);
            end
            n_vec++;
            if (obs_hung || obs_lat != 258 + w || obs_rdata !== odata || obs_rtag !== tag || obs_rto !== 1'b0) begin
                n_err++; $display("FAIL b2b_%0d_resp: got lat=%0d %h/%h to=%b want lat=%0d %h/%h to=0",
                                  t, obs_lat, obs_rdata, obs_rtag, obs_rto, 258 + w, odata, tag);
            end
        end
    endtask

    initial begin
        test_reset();
        test_encrypt_vector();
        test_timeout();
        test_timeout_edge();
        test_resp_hold();
        test_decrypt();
        test_abort(41, "load");
        test_abort(164, "capture");
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
